// File: rtl/sw_debounce_hit.sv
// Switch front end: synchronises, debounces and edge-detects raw slide switches, then reduces
// the rising edges to a single registered hit event for the game/score stage.
// Latency: 2 sync cycles + (STABLE_TICKS-1)*TICK_DIV+1 .. STABLE_TICKS*TICK_DIV cycles to sw_db,
//          with edge pulses in the same cycle as the sw_db change and the hit event one cycle later.
// Backpressure: none. The outputs are pulses and levels, and the consumer must sample every cycle.
//
// Ports:
//   clk        system clock; all state changes on the rising edge
//   rst        synchronous active-high reset; clears every register
//   sw         raw switch levels, asynchronous to clk
//   sw_db      debounced switch levels
//   sw_rise    one-cycle pulse per channel on a debounced 0->1
//   sw_fall    one-cycle pulse per channel on a debounced 1->0
//   hit_valid  one-cycle pulse, one cycle after any sw_rise bit
//   hit_idx    lowest rising channel of the last hit; holds between hits
//   hit_multi  high with hit_valid when more than one channel rose together
module sw_debounce_hit #(
    parameter int N_SW         = 16,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 10,
    localparam int IDX_W       = (N_SW > 1) ? $clog2(N_SW) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_SW-1:0]   sw,
    output logic [N_SW-1:0]   sw_db,
    output logic [N_SW-1:0]   sw_rise,
    output logic [N_SW-1:0]   sw_fall,
    output logic              hit_valid,
    output logic [IDX_W-1:0]  hit_idx,
    output logic              hit_multi
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_W = (STABLE_TICKS > 0) ? $clog2(STABLE_TICKS + 1) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);
    localparam logic [N_SW-1:0]  ONE_VEC  = {{(N_SW-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Two-flop synchroniser; only s2 is trusted downstream.
    // ------------------------------------------------------------------
    logic [N_SW-1:0] s1;
    logic [N_SW-1:0] s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw;
            s2 <= s1;
        end
    end

    // ------------------------------------------------------------------
    // Free-running sample prescaler shared by all channels.
    // ------------------------------------------------------------------
    logic [PRE_W-1:0] pre;
    logic             tick;

    assign tick = (pre == PRE_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel debounce. The counter only advances on ticks while the
    // synchronised input disagrees with the accepted level; any cycle of
    // agreement clears it, so a bouncing contact never accumulates.
    // Edge pulses are produced here so they line up with the sw_db change.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt [N_SW];

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_db   <= '0;
            sw_rise <= '0;
            sw_fall <= '0;
            for (int i = 0; i < N_SW; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sw_rise <= '0;
            sw_fall <= '0;
            for (int i = 0; i < N_SW; i++) begin
                if (s2[i] == sw_db[i]) begin
                    cnt[i] <= '0;
                end else if (tick) begin
                    if (cnt[i] == CNT_LAST) begin
                        sw_db[i]   <= s2[i];
                        sw_rise[i] <= s2[i];
                        sw_fall[i] <= ~s2[i];
                        cnt[i]     <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Hit reduction of the registered rise vector.
    // Scanning from the top down leaves the lowest set index in low_idx.
    // x & (x-1) clears the lowest set bit; anything left means >1 rise.
    // ------------------------------------------------------------------
    logic             any_rise;
    logic             many_rise;
    logic [IDX_W-1:0] low_idx;

    always_comb begin
        low_idx = '0;
        for (int i = N_SW - 1; i >= 0; i--) begin
            if (sw_rise[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    assign any_rise  = |sw_rise;
    assign many_rise = |(sw_rise & (sw_rise - ONE_VEC));

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_valid <= 1'b0;
            hit_idx   <= '0;
            hit_multi <= 1'b0;
        end else begin
            hit_valid <= any_rise;
            hit_multi <= any_rise & many_rise;
            if (any_rise) begin
                hit_idx <= low_idx;
            end
        end
    end

endmodule

// File: doc/sw_debounce_hit.md
Name: sw_debounce_hit

Overview:
Upstream front end for the 16-switch hit game. It takes the raw, asynchronous, bouncing slide switches, synchronises and debounces each one, and produces clean per-switch level and edge signals. It also produces a single registered hit event (index plus multi-hit flag) that the game/score stage consumes instead of raw switch levels.

Parameters:
N_SW, 16, number of switch channels; hit_idx width is clog2(N_SW).
TICK_DIV, 50000, clk cycles per debounce sample tick (1 ms at 50 MHz); must be >= 2.
STABLE_TICKS, 10, consecutive mismatching ticks required before a new level is accepted; must be >= 1.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
sw  input  N_SW  raw switch inputs, asynchronous to clk.
sw_db  output  N_SW  debounced switch levels.
sw_rise  output  N_SW  one-cycle pulse per channel on debounced 0->1.
sw_fall  output  N_SW  one-cycle pulse per channel on debounced 1->0.
hit_valid  output  1  one-cycle pulse when any sw_rise bit was set in the previous cycle.
hit_idx  output  clog2(N_SW)  lowest index among those rises; held between events.
hit_multi  output  1  set with hit_valid when more than one rise occurred in the same cycle.

Behaviour:
- Reset: when rst=1 at a clk edge, all of the following clear to 0: sync flops, prescaler, per-channel counters, sw_db, sw_rise, sw_fall, hit_valid, hit_idx, hit_multi. Reset has priority over all other activity.
- Synchroniser: two flops per channel, s1 <= sw, s2 <= s1. Only s2 is used downstream.
- Prescaler:
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - tick is high for one cycle when the counter equals TICK_DIV-1.
  - Free-running; restarts from 0 after reset.
- Per-channel debounce, counter cnt[i] of width clog2(STABLE_TICKS+1):
  - s2[i]==sw_db[i]: cnt[i] <= 0. Any agreement cycle restarts the count, which rejects bounce.
  - s2[i]!=sw_db[i] and tick=1 and cnt[i]==STABLE_TICKS-1: sw_db[i] <= s2[i], cnt[i] <= 0.
  - s2[i]!=sw_db[i] and tick=1 otherwise: cnt[i] <= cnt[i]+1.
  - s2[i]!=sw_db[i] and tick=0: cnt[i] holds.
- Latency:
  - From a clean, held sw edge to the sw_db change: 2 sync cycles + between (STABLE_TICKS-1)*TICK_DIV+1 and STABLE_TICKS*TICK_DIV cycles, depending on prescaler phase.
  - STABLE_TICKS=1 means acceptance on the first tick.
- Edge pulses:
  - sw_rise[i] and sw_fall[i] are registered and asserted in the same cycle that sw_db[i] shows its new value.
  - Each pulse is exactly one cycle long. sw_rise[i] and sw_fall[i] are never high together.
- Hit event, registered one cycle after sw_rise:
  - hit_valid <= |sw_rise.
  - When |sw_rise=1: hit_idx <= index of lowest set bit of sw_rise, and hit_multi <= (popcount(sw_rise) > 1).
  - When |sw_rise=0: hit_idx holds its last value and hit_multi <= 0.
  - Falling edges never generate hit_valid.
- Simultaneous events:
  - Channels are fully independent.
  - Several channels accepting on the same tick produce the same-cycle rise pulses and one hit_valid with hit_multi=1.
- Switch held high through reset:
  - sw_db restarts at 0, so a held switch produces one sw_rise, and one hit, a full debounce period after rst deasserts. This is intended.
- Reset mid-count:
  - Partial counts are discarded and no pulse is emitted.
  - Debounce restarts from scratch after rst deasserts.
- Output behaviour: no combinational path from sw to any output; all outputs are registered.

Test Plan:
(Simulation parameters: TICK_DIV=4, STABLE_TICKS=3, N_SW=16.)
1. rst=1 for 3 cycles with sw=16'hFFFF -> all outputs 0 during reset. After release, sw_db reaches 16'hFFFF within 2+12 cycles and no earlier than 2+9. sw_rise=16'hFFFF for exactly 1 cycle. Next cycle hit_valid=1, hit_idx=0, hit_multi=1.
2. From reset with sw=0, set sw[5]=1 and hold -> sw_db[5]=1 after 11..14 cycles. sw_rise=16'h0020 for 1 cycle. Next cycle hit_valid=1, hit_idx=5, hit_multi=0. hit_valid then stays 0.
3. Bounce: toggle sw[3] every 5 cycles for 60 cycles, then hold 0 -> sw_db[3] stays 0, sw_rise and sw_fall stay 0, hit_valid never asserts.
4. Set sw[9] and sw[2] in the same cycle -> both sw_db bits set on the same cycle. sw_rise=16'h0204. Next cycle hit_valid=1, hit_idx=2, hit_multi=1.
5. Release sw[5] after case 2 -> sw_fall[5]=1 for 1 cycle, 11..14 cycles later. hit_valid stays 0 and hit_idx stays 5.
6. Set sw[7]=1, then assert rst for 1 cycle after 8 cycles, with sw[7] still high -> no pulse before rst. sw_rise[7] fires 11..14 cycles after rst deasserts. hit_idx=7.
